pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline controller for the 5-stage RV32 core. It is the successor to the standalone hazard unit. It adds:
- per-stage valid tracking;
- hazard checks for branches resolved in ID;
- ID-stage forwarding selects;
- freeze support for multi-cycle EX operations (divider/multiplier) with a timeout;
- saturating performance counters.

It drives every PC and inter-stage register enable, flush and bubble in the datapath.

## Interface
- RegAddress, 5, register-specifier width
- MC_TIMEOUT, 64, max cycles a multi-cycle op may stay busy before a forced release
- CNT_W, 32, performance counter width
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- id_rs1, id_rs2  in  RegAddress  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads that source
- id_is_branch  in  1  ID instruction compares or uses operands in ID (branch/jalr)
- branch_taken  in  1  ID comparator/control requests redirect
- ex_rd, mem_rd  in  RegAddress  destination register in ID/EX and EX/MEM
- ex_regwrite, ex_memread, mem_regwrite, mem_memread  in  1  control bits of those stages
- ex_mc  in  1  instruction in EX is multi-cycle
- mc_done  in  1  multi-cycle unit result ready (1-cycle pulse)
- pc_we, ifid_we, idex_we  out  1  register enables
- ifid_flush  out  1  clear IF/ID on the next edge
- idex_bubble  out  1  zero ID/EX control on the next edge
- exmem_bubble  out  1  zero EX/MEM control on the next edge
- pc_sel_branch  out  1  select branch target for the next PC
- fwd_id_a, fwd_id_b  out  1  ID comparator operand takes the EX/MEM ALU result
- stage_valid  out  4  {WB, MEM, EX, ID} valid bits
- mc_error  out  1  sticky; a multi-cycle op timed out
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
**Hazard terms** (all require rd != 0 and the matching id_use_*):
- **load_use**: ex_memread & ex_regwrite & ex_rd matches a used source.
- **br_ex**: id_is_branch & ex_regwrite & ex_rd match.
- **br_mem_ld**: id_is_branch & mem_memread & mem_rd match.
- **hz** = stage_valid[0] & (load_use | br_ex | br_mem_ld).

**Forwarding selects**
- fwd_id_a = id_is_branch & mem_regwrite & ~mem_memread & mem_rd==id_rs1 & mem_rd!=0 & stage_valid[2].
- fwd_id_b is the same using id_rs2.

**Multi-cycle FSM**, states IDLE, BUSY:
- IDLE→BUSY when stage_valid[1] & ex_mc; the timeout counter is cleared on entry.
- BUSY→IDLE on mc_done, or when the counter reaches MC_TIMEOUT-1. A timeout sets mc_error.
- **freeze** = (IDLE & stage_valid[1] & ex_mc) | (BUSY & ~mc_done & ~timeout).

**Priority** (highest first):
1. **freeze**: pc_we = ifid_we = idex_we = 0; exmem_bubble = 1; ID/EX/IF state held; branch_taken ignored.
2. **hz**: pc_we = ifid_we = 0; idex_bubble = 1; pc_sel_branch = 0.
3. **branch**: branch_taken & stage_valid[0] → pc_sel_branch = 1, ifid_flush = 1.

**Valid bits**
- Update every edge unless frozen, as follows:
  - v_id ← ~ifid_flush (or held when ifid_we = 0);
  - v_ex ← v_id & ~hz;
  - v_mem ← v_ex;
  - v_wb ← v_mem.
- During freeze: v_id and v_ex are held, v_mem ← 0, v_wb ← v_mem.
- Write enables downstream are gated externally by stage_valid.

**Counters**
- stall_cnt +1 each cycle freeze | hz.
- flush_cnt +1 per ifid_flush.
- Both saturate at all-ones.

## Timing
- All control outputs (enables, bubbles, flush, pc_sel_branch, fwd_*) are combinational from the inputs and registered state. They act on the next rising edge.
- Registered: stage_valid, FSM state, timeout counter, mc_error, stall_cnt, flush_cnt.
- **Reset** (rst=0 at an edge):
  - stage_valid = 0, FSM = IDLE, counters = 0, mc_error = 0.
  - While rst=0: pc_we = ifid_we = idex_we = 0 and flush/bubbles = 1.
  - Reset mid-BUSY aborts the op with no error.
- **Latencies**:
  - load-use: exactly 1 stall cycle.
  - br_ex: 1 cycle, or 2 if the EX producer is a load (br_ex then br_mem_ld).
  - Multi-cycle op of N cycles: N+1 frozen cycles counted from entry into EX.
  - Taken branch: 1 flushed slot.
- **Simultaneous events**:
  - mc_done and a new ex_mc in the same cycle: release first; the next instruction re-enters IDLE→BUSY only after it reaches EX.
  - hz with branch_taken: the branch is ignored and re-evaluated next cycle.
  - mc_done in IDLE is ignored.

## Structure
- **Package pipe_ctrl_pkg**:
  - mc_state_t enum {IDLE, BUSY};
  - stage index constants ST_ID=0, ST_EX=1, ST_MEM=2, ST_WB=3;
  - hazard cause enum {HZ_NONE, HZ_LOADUSE, HZ_BR_EX, HZ_BR_MEMLD} (exposed for debug).
- **Sub-module pipe_hazard_detect**: combinational hz terms plus fwd_id_a/b. pipe_ctrl instantiates it and holds the FSM, valid bits and counters.

## Test plan
- **Load-use**: lw x5 in EX (ex_memread=1, ex_rd=5), ID add reads rs1=5 → one cycle pc_we=0, idex_bubble=1; stage_valid[1]=0 the next cycle; stall_cnt=1.
- **Branch after load**: lw x7 followed by beq x7,x0 → 2 stall cycles (br_ex, then br_mem_ld). Third cycle branch_taken → pc_sel_branch=1, ifid_flush=1; flush_cnt=1.
- **Branch after ALU op**: add x3 then 1-bubble-separated beq x3 → fwd_id_a=1 with no stall when the add is in MEM.
- **Multi-cycle**: ex_mc=1 with mc_done after 4 cycles → 5 frozen cycles with exmem_bubble=1; stage_valid[2]=0 in each; mc_error=0.
- **Timeout**: MC_TIMEOUT=8, mc_done never asserted → release after 8 cycles; mc_error=1 and stays 1 until reset.
- **Reset mid-BUSY and saturation**: rst low during BUSY → next cycle FSM IDLE, stage_valid=0, counters 0. With CNT_W=4, 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller and its hazard detector.
package pipe_ctrl_pkg;

    typedef enum logic {IDLE, BUSY} mc_state_t;

    localparam int ST_ID  = 0;
    localparam int ST_EX  = 1;
    localparam int ST_MEM = 2;
    localparam int ST_WB  = 3;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_LOADUSE,
        HZ_BR_EX,
        HZ_BR_MEMLD
    } hz_cause_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> pipeline controller signal bundle; master is the controller side.
interface pipe_ctrl_if #(
    parameter int RegAddress = 5,
    parameter int CNT_W      = 32
);
    logic [RegAddress-1:0] id_rs1;
    logic [RegAddress-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_is_branch;
    logic                  branch_taken;
    logic [RegAddress-1:0] ex_rd;
    logic [RegAddress-1:0] mem_rd;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic                  mem_regwrite;
    logic                  mem_memread;
    logic                  ex_mc;
    logic                  mc_done;

    logic                  pc_we;
    logic                  ifid_we;
    logic                  idex_we;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  exmem_bubble;
    logic                  pc_sel_branch;
    logic                  fwd_id_a;
    logic                  fwd_id_b;
    logic [3:0]            stage_valid;
    logic                  mc_error;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, branch_taken,
               ex_rd, mem_rd, ex_regwrite, ex_memread, mem_regwrite, mem_memread,
               ex_mc, mc_done,
        output pc_we, ifid_we, idex_we, ifid_flush, idex_bubble, exmem_bubble,
               pc_sel_branch, fwd_id_a, fwd_id_b, stage_valid, mc_error,
               stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, branch_taken,
               ex_rd, mem_rd, ex_regwrite, ex_memread, mem_regwrite, mem_memread,
               ex_mc, mc_done,
        input  pc_we, ifid_we, idex_we, ifid_flush, idex_bubble, exmem_bubble,
               pc_sel_branch, fwd_id_a, fwd_id_b, stage_valid, mc_error,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational ID-stage hazard classification and EX/MEM -> ID comparator forwarding.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RegAddress = 5
) (
    input  logic [RegAddress-1:0] id_rs1,
    input  logic [RegAddress-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_branch,
    input  logic [RegAddress-1:0] ex_rd,
    input  logic [RegAddress-1:0] mem_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic                  mem_regwrite,
    input  logic                  mem_memread,
    input  logic                  mem_valid,
    output hz_cause_t             hz_cause,
    output logic                  fwd_id_a,
    output logic                  fwd_id_b
);

    function automatic logic src_hit(input logic [RegAddress-1:0] rd,
                                     input logic [RegAddress-1:0] rs1,
                                     input logic [RegAddress-1:0] rs2,
                                     input logic use1,
                                     input logic use2);
        return (rd != '0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_ex;
    logic br_mem_ld;
    logic mem_fwd;

    always_comb begin
        ex_hit    = src_hit(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
        mem_hit   = src_hit(mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
        load_use  = ex_memread && ex_regwrite && ex_hit;
        br_ex     = id_is_branch && ex_regwrite && ex_hit;
        br_mem_ld = id_is_branch && mem_memread && mem_hit;

        // Several causes can coexist; the reported one is only for debug visibility.
        hz_cause = HZ_NONE;
        if (load_use)       hz_cause = HZ_LOADUSE;
        else if (br_ex)     hz_cause = HZ_BR_EX;
        else if (br_mem_ld) hz_cause = HZ_BR_MEMLD;

        mem_fwd  = id_is_branch && mem_regwrite && !mem_memread && mem_valid && (mem_rd != '0);
        fwd_id_a = mem_fwd && (mem_rd == id_rs1);
        fwd_id_b = mem_fwd && (mem_rd == id_rs2);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush/freeze priority, per-stage valid bits, multi-cycle
// EX tracking with timeout, and saturating stall/flush counters.
//   state | meaning
//   IDLE  | no multi-cycle op outstanding
//   BUSY  | multi-cycle op in EX, waiting for mc_done or timeout
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RegAddress = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master bus
);

    localparam int MC_TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

    mc_state_t        mc_state;
    logic [MC_TW-1:0] mc_left;
    logic             mc_error_q;
    logic [3:0]       valid_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    hz_cause_t hz_cause;
    logic      fwd_a;
    logic      fwd_b;
    logic      hz;
    logic      mc_timeout;
    logic      freeze;
    logic      pc_we;
    logic      ifid_we;
    logic      idex_we;
    logic      ifid_flush;
    logic      idex_bubble;
    logic      exmem_bubble;
    logic      pc_sel_branch;

    pipe_hazard_detect #(.RegAddress(RegAddress)) u_hazard (
        .id_rs1       (bus.id_rs1),
        .id_rs2       (bus.id_rs2),
        .id_use_rs1   (bus.id_use_rs1),
        .id_use_rs2   (bus.id_use_rs2),
        .id_is_branch (bus.id_is_branch),
        .ex_rd        (bus.ex_rd),
        .mem_rd       (bus.mem_rd),
        .ex_regwrite  (bus.ex_regwrite),
        .ex_memread   (bus.ex_memread),
        .mem_regwrite (bus.mem_regwrite),
        .mem_memread  (bus.mem_memread),
        .mem_valid    (valid_q[ST_MEM]),
        .hz_cause     (hz_cause),
        .fwd_id_a     (fwd_a),
        .fwd_id_b     (fwd_b)
    );

    always_comb begin
        mc_timeout = (mc_state == BUSY) && (mc_left == '0);
        freeze     = ((mc_state == IDLE) && valid_q[ST_EX] && bus.ex_mc) ||
                     ((mc_state == BUSY) && !bus.mc_done && !mc_timeout);
        hz         = valid_q[ST_ID] && (hz_cause != HZ_NONE);

        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idex_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        pc_sel_branch = 1'b0;
        if (!rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (freeze) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
        end else if (hz) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.branch_taken && valid_q[ST_ID]) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
        end
    end

    // mc_left counts down from MC_TIMEOUT-1; reaching zero in BUSY is the timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mc_state   <= IDLE;
            mc_left    <= '0;
            mc_error_q <= 1'b0;
        end else begin
            case (mc_state)
                IDLE: begin
                    if (valid_q[ST_EX] && bus.ex_mc) begin
                        mc_state <= BUSY;
                        mc_left  <= MC_TW'(MC_TIMEOUT - 1);
                    end
                end
                BUSY: begin
                    if (bus.mc_done) begin
                        mc_state <= IDLE;
                    end else if (mc_timeout) begin
                        mc_state   <= IDLE;
                        mc_error_q <= 1'b1;
                    end else begin
                        mc_left <= mc_left - MC_TW'(1);
                    end
                end
                default: mc_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (freeze) begin
                valid_q[ST_MEM] <= 1'b0;
                valid_q[ST_WB]  <= valid_q[ST_MEM];
            end else begin
                if (ifid_we) valid_q[ST_ID] <= !ifid_flush;
                valid_q[ST_EX]  <= valid_q[ST_ID] && !hz;
                valid_q[ST_MEM] <= valid_q[ST_EX];
                valid_q[ST_WB]  <= valid_q[ST_MEM];
            end
            if ((freeze || hz) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && (flush_q != '1))     flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.pc_we         = pc_we;
    assign bus.ifid_we       = ifid_we;
    assign bus.idex_we       = idex_we;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_bubble   = idex_bubble;
    assign bus.exmem_bubble  = exmem_bubble;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.fwd_id_a      = fwd_a;
    assign bus.fwd_id_b      = fwd_b;
    assign bus.stage_valid   = valid_q;
    assign bus.mc_error      = mc_error_q;
    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;

endmodule
